// File: rtl/gf2_rank_pipe.sv
// gf2_rank_pipe: row-streaming GF(2) Gaussian elimination / rank engine.
//
// A ROWS x DAT_W binary matrix is streamed in one row per handshake. Each row
// walks a DAT_W-stage pipeline, one stage per column. A stage either cancels
// its column against the stored pivot for that column or, if no pivot exists
// yet, becomes that pivot. Rows that survive every stage are linearly
// dependent and are dropped. The rank is the number of pivots that get stored.
//
// Ports:
//   clk, rst_b          clock, asynchronous active-low reset
//   start               begin a new matrix (only honoured in IDLE)
//   row_valid/row_ready row handshake; row_data bit DAT_W-1 is column 0
//   busy                high in LOAD, DRAIN and DONE
//   finish              one-cycle pulse, rank/full_rank valid from here on
//   rank, full_rank     pivot count, and rank == min(ROWS, DAT_W)
//
// Build option: define PIVOT_READ_EN to add a combinational pivot read port
//   (piv_addr -> piv_data, piv_vld).

module gf2_rank_stage #(
  parameter int DAT_W = 4,
  parameter int COL   = 0
) (
  input  logic [DAT_W-1:0] row_in,
  input  logic             vld_in,
  input  logic [DAT_W-1:0] piv,
  input  logic             piv_vld,
  output logic [DAT_W-1:0] row_out,
  output logic             vld_out,
  output logic             wr
);
  logic b;
  assign b = row_in[DAT_W-1-COL];

  // A stored pivot always has its own column bit set, so XOR clears it.
  always_comb begin
    wr      = vld_in & b & ~piv_vld;
    row_out = (b & piv_vld) ? (row_in ^ piv) : row_in;
    vld_out = vld_in & ~wr;
  end
endmodule

module gf2_rank_pipe #(
  parameter int DAT_W = 4,
  parameter int ROWS  = 4,
  parameter int RNK_W = $clog2(DAT_W+1)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     start,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [DAT_W-1:0]         row_data,
  output logic                     busy,
  output logic                     finish,
  output logic [RNK_W-1:0]         rank,
  output logic                     full_rank
`ifdef PIVOT_READ_EN
  ,
  input  logic [$clog2(DAT_W)-1:0] piv_addr,
  output logic [DAT_W-1:0]         piv_data,
  output logic                     piv_vld
`endif
);
  localparam int CW    = $clog2(ROWS+1);
  localparam int DW    = $clog2(DAT_W+1);
  localparam int MINRC = (ROWS < DAT_W) ? ROWS : DAT_W;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]                cnt;
  logic [DW-1:0]                dcnt;
  logic [DAT_W-1:0][DAT_W-1:0]  stg_row, out_row, piv;
  logic [DAT_W-1:0]             vld_pipe, out_vld, wr, pv, pv_nxt;
  logic                         go, acc, last_acc, drain_end;
  logic [RNK_W-1:0]             rank_nxt;
  logic                         unused_tail;

  assign row_ready = (state == LOAD);
  assign busy      = (state != IDLE);
  assign finish    = (state == DONE);
  assign go        = (state == IDLE) && start;
  assign acc       = row_valid && row_ready;
  assign last_acc  = acc && (cnt == CW'(ROWS-1));
  assign drain_end = (state == DRAIN) && (dcnt == DW'(DAT_W-1));

  // Rank is latched on the same edge the last stage may still commit a
  // pivot, so count the post-edge pivot set.
  assign pv_nxt = pv | wr;
  always_comb begin
    rank_nxt = '0;
    for (int j = 0; j < DAT_W; j++) rank_nxt = rank_nxt + RNK_W'(pv_nxt[j]);
  end

  for (genvar j = 0; j < DAT_W; j++) begin : g_stg
    gf2_rank_stage #(.DAT_W(DAT_W), .COL(j)) u_stg (
      .row_in (stg_row[j]),
      .vld_in (vld_pipe[j]),
      .piv    (piv[j]),
      .piv_vld(pv[j]),
      .row_out(out_row[j]),
      .vld_out(out_vld[j]),
      .wr     (wr[j])
    );
  end

  // Survivors of the last stage are dependent rows and are discarded.
  assign unused_tail = ^{out_row[DAT_W-1], out_vld[DAT_W-1]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stg_row  <= '0;
      vld_pipe <= '0;
    end else begin
      stg_row[0]  <= row_data;
      vld_pipe[0] <= acc;
      for (int j = 1; j < DAT_W; j++) begin
        stg_row[j]  <= out_row[j-1];
        vld_pipe[j] <= out_vld[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      piv <= '0;
      pv  <= '0;
    end else if (go) begin
      piv <= '0;
      pv  <= '0;
    end else begin
      for (int j = 0; j < DAT_W; j++) begin
        if (wr[j]) begin
          piv[j] <= stg_row[j];
          pv[j]  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      rank      <= '0;
      full_rank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go)       cnt <= '0;
      else if (acc) cnt <= cnt + 1'b1;
      if (last_acc)              dcnt <= '0;
      else if (state == DRAIN)   dcnt <= dcnt + 1'b1;
      if (go) begin
        rank      <= '0;
        full_rank <= 1'b0;
      end else if (drain_end) begin
        rank      <= rank_nxt;
        full_rank <= (rank_nxt == RNK_W'(MINRC));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LOAD;
      LOAD:    if (last_acc)  state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

`ifdef PIVOT_READ_EN
  always_comb begin
    piv_data = '0;
    piv_vld  = 1'b0;
    if (int'(piv_addr) < DAT_W) begin
      piv_data = piv[piv_addr];
      piv_vld  = pv[piv_addr];
    end
  end
`endif
endmodule
